// File: rtl/pkt_arbiter_pkg.sv
// Shared types and constants for the packet arbiter: FSM states, tag nibble
// and byte-counter width.
package pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAG     = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_t;

    localparam logic [3:0]  TAG_NIBBLE = 4'hA;
    localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/pkt_arbiter_rr_pick.sv
// Combinational round-robin search: first requester strictly after 'last',
// wrapping modulo N_PAIR.
module rr_pick
    import pkt_arbiter_pkg::*;
#(
    parameter int unsigned N_PAIR = 2
) (
    input  logic [N_PAIR-1:0] req,
    input  logic [2:0]        last,
    output logic [N_PAIR-1:0] grant,
    output logic              found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_PAIR; k++) begin
            int unsigned pos;
            pos = 32'(last) + k;
            if (pos >= N_PAIR) begin
                pos = pos - N_PAIR;
            end
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_arbiter.sv
// Round-robin packet arbiter: picks one non-empty enabled FIFO, optionally
// emits a tag byte, then streams PKT_LEN payload bytes onto the BytePipe.
module pkt_arbiter
    import pkt_arbiter_pkg::*;
#(
    parameter int unsigned N_PAIR  = 2,
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned TAG_EN  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cg,
    input  logic [N_PAIR-1:0]     i_enable,
    input  logic [N_PAIR*8-1:0]   i_pktfifo_data,
    input  logic [N_PAIR-1:0]     i_pktfifo_empty,
    output logic [N_PAIR-1:0]     o_pktfifo_pop,
    output logic [7:0]            o_bp_data,
    output logic                  o_bp_valid,
    input  logic                  i_bp_ready,
    output logic [N_PAIR-1:0]     o_grant,
    output logic                  o_busy
);

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_PAIR-1:0]  grant_q, grant_d;
    logic [2:0]         last_q, last_d;

    logic [N_PAIR-1:0]  pick_grant;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic [7:0]         cur_data;
    logic               cur_empty;

    rr_pick #(.N_PAIR(N_PAIR)) u_rr_pick (
        .req   (i_enable & ~i_pktfifo_empty),
        .last  (last_q),
        .grant (pick_grant),
        .found (pick_found)
    );

    // last_q doubles as the index of the pair currently owning the output
    always_comb begin
        pick_idx  = '0;
        cur_data  = '0;
        cur_empty = 1'b1;
        for (int unsigned i = 0; i < N_PAIR; i++) begin
            if (pick_grant[i]) begin
                pick_idx = 3'(i);
            end
            if (3'(i) == last_q) begin
                cur_data  = i_pktfifo_data[i*8 +: 8];
                cur_empty = i_pktfifo_empty[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= 3'(N_PAIR - 1);
        end else if (i_cg) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_d        = last_q;
        o_bp_valid    = 1'b0;
        o_bp_data     = '0;
        o_pktfifo_pop = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_grant;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = (TAG_EN != 0) ? TAG : PAYLOAD;
                end
            end
            TAG: begin
                o_bp_valid = 1'b1;
                o_bp_data  = {TAG_NIBBLE, 1'b0, last_q};
                if (i_bp_ready) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                end
            end
            PAYLOAD: begin
                o_bp_valid = !cur_empty;
                o_bp_data  = cur_data;
                if (!cur_empty && i_bp_ready) begin
                    o_pktfifo_pop = grant_q;
                    if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are masked last so reset and clock-gating override every state
        if (!i_rst || !i_cg) begin
            o_bp_valid    = 1'b0;
            o_pktfifo_pop = '0;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pkt_arbiter.sv
// Self-checking bench for pkt_arbiter (N_PAIR=2, PKT_LEN=4, TAG_EN=1):
// cycle vector table for reset/first packet, scoreboard for multi-packet cases.
module tb_pkt_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned PL = 4;

    logic          clk = 1'b0;
    logic          i_rst, i_cg, i_bp_ready;
    logic [NP-1:0] i_enable, i_pktfifo_empty, o_pktfifo_pop, o_grant;
    logic [NP*8-1:0] i_pktfifo_data;
    logic [7:0]    o_bp_data;
    logic          o_bp_valid, o_busy;

    pkt_arbiter #(.N_PAIR(NP), .PKT_LEN(PL), .TAG_EN(1)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_cg            (i_cg),
        .i_enable        (i_enable),
        .i_pktfifo_data  (i_pktfifo_data),
        .i_pktfifo_empty (i_pktfifo_empty),
        .o_pktfifo_pop   (o_pktfifo_pop),
        .o_bp_data       (o_bp_data),
        .o_bp_valid      (o_bp_valid),
        .i_bp_ready      (i_bp_ready),
        .o_grant         (o_grant),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    data;
        logic [NP-1:0] grant;
        bit            tag;
        int            gap;
    } sb_t;

    typedef struct {
        bit            rst, cg, rdy;
        bit            exp_valid;
        logic [7:0]    exp_data;
        logic [NP-1:0] exp_pop, exp_grant;
        bit            exp_busy;
    } vec_t;

    sb_t        sb[$];
    logic [7:0] fq0[$], fq1[$];
    bit         rst_s = 0, cg_s = 1, rdy_s = 1;
    logic [NP-1:0] en_s = 2'b11;
    logic [NP-1:0] pop_seen = '0;
    bit         sb_en = 0, hs_now = 0;
    logic [7:0] hs_data = '0;
    int         cycle = 0, last_hs_cycle = 0;
    int         n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic monitor();
        sb_t e;
        hs_now   = o_bp_valid && i_bp_ready;
        pop_seen = o_pktfifo_pop;
        if (hs_now) hs_data = o_bp_data;
        if (sb_en) begin
            if (hs_now) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra: got byte %h expected no transfer", o_bp_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(o_bp_data), 32'(e.data));
                    check("sb_grant", 32'(o_grant), 32'(e.grant));
                    check("sb_pop", 32'(o_pktfifo_pop), e.tag ? 32'd0 : 32'(e.grant));
                    if (e.gap != 0) check("sb_gap", 32'(cycle - last_hs_cycle), 32'(e.gap));
                end
                last_hs_cycle = cycle;
            end else begin
                check("idle_pop", 32'(o_pktfifo_pop), 32'd0);
            end
        end
    endtask

    // Inputs change only just after a rising edge, so each monitor sample
    // reflects exactly what the DUT sees at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (pop_seen[1] && fq1.size() > 0) void'(fq1.pop_front());
        i_rst      = rst_s;
        i_cg       = cg_s;
        i_bp_ready = rdy_s;
        i_enable   = en_s;
        i_pktfifo_empty = {fq1.size() == 0, fq0.size() == 0};
        i_pktfifo_data  = {(fq1.size() > 0) ? fq1[0] : 8'h00, (fq0.size() > 0) ? fq0[0] : 8'h00};
        cycle++;
        @(negedge clk);
        monitor();
    endtask

    task automatic load(input int pair, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (pair == 0) fq0.push_back(base + 8'(k));
            else           fq1.push_back(base + 8'(k));
        end
    endtask

    task automatic push_pkt(input int pair, input logic [7:0] base, input int tag_gap);
        logic [NP-1:0] g;
        g = (pair == 0) ? 2'b01 : 2'b10;
        sb.push_back('{data: {4'hA, 1'b0, 3'(pair)}, grant: g, tag: 1'b1, gap: tag_gap});
        for (int k = 0; k < int'(PL); k++)
            sb.push_back('{data: base + 8'(k), grant: g, tag: 1'b0, gap: 1});
    endtask

    task automatic run_until_hs(input logic [7:0] d, input int budget);
        bit hit;
        hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            tick();
            if (hs_now && hs_data == d) hit = 1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL wait_byte: got no transfer of %h expected one within %0d cycles", d, budget);
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_s = 0;
        tick();
        tick();
        rst_s = 1;
        tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
    endtask

    vec_t vt[11];

    initial begin
        i_rst = 0; i_cg = 1; i_bp_ready = 1; i_enable = 2'b11;
        i_pktfifo_empty = 2'b11; i_pktfifo_data = '0;

        //             rst cg rdy  v  data   pop    grant  busy
        vt[0]  = '{0, 1, 1, 0, 8'h00, 2'b00, 2'b00, 0};
        vt[1]  = '{1, 1, 1, 0, 8'h00, 2'b00, 2'b00, 0};
        vt[2]  = '{1, 1, 1, 1, 8'hA0, 2'b00, 2'b01, 1};
        vt[3]  = '{1, 1, 1, 1, 8'h01, 2'b01, 2'b01, 1};
        vt[4]  = '{1, 0, 1, 0, 8'h00, 2'b00, 2'b01, 1};
        vt[5]  = '{1, 0, 1, 0, 8'h00, 2'b00, 2'b01, 1};
        vt[6]  = '{1, 1, 1, 1, 8'h02, 2'b01, 2'b01, 1};
        vt[7]  = '{1, 1, 1, 1, 8'h03, 2'b01, 2'b01, 1};
        vt[8]  = '{1, 1, 1, 1, 8'h04, 2'b01, 2'b01, 1};
        vt[9]  = '{1, 1, 1, 0, 8'h00, 2'b00, 2'b00, 0};
        vt[10] = '{1, 1, 1, 0, 8'h00, 2'b00, 2'b00, 0};

        // Single tagged packet from pair 0, with a clock-gate hold mid-payload
        load(0, 8'h01, 4);
        for (int i = 0; i < 11; i++) begin
            rst_s = vt[i].rst; cg_s = vt[i].cg; rdy_s = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(o_bp_valid), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(o_bp_data), 32'(vt[i].exp_data));
            check($sformatf("vec%0d_pop", i), 32'(o_pktfifo_pop), 32'(vt[i].exp_pop));
            check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vt[i].exp_grant));
            check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vt[i].exp_busy));
        end
        check("vec_fifo0_left", 32'(fq0.size()), 32'd0);

        // Alternating grants with a single bubble between packets
        sb_en = 1;
        do_reset();
        push_pkt(0, 8'h10, 0); push_pkt(1, 8'h20, 2);
        push_pkt(0, 8'h30, 2); push_pkt(1, 8'h40, 2);
        load(0, 8'h10, 4); load(1, 8'h20, 4); load(0, 8'h30, 4); load(1, 8'h40, 4);
        drain(60);
        tick();
        check("alt_idle_busy", 32'(o_busy), 32'd0);

        // Ready stall of three cycles mid-payload
        push_pkt(0, 8'h50, 0);
        sb[sb.size()-2].gap = 4;
        load(0, 8'h50, 4);
        run_until_hs(8'h51, 20);
        rdy_s = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(o_bp_valid), 32'd1);
            check("stall_data", 32'(o_bp_data), 32'h52);
            check("stall_pop", 32'(o_pktfifo_pop), 32'd0);
        end
        rdy_s = 1;
        drain(20);

        // FIFO underflow after byte 2, refilled five cycles later
        do_reset();
        push_pkt(0, 8'h60, 0);
        sb[sb.size()-2].gap = 6;
        load(0, 8'h60, 2);
        run_until_hs(8'h61, 20);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("uflow_valid", 32'(o_bp_valid), 32'd0);
            check("uflow_grant", 32'(o_grant), 32'h1);
            check("uflow_busy", 32'(o_busy), 32'd1);
        end
        load(0, 8'h62, 2);
        tick();
        check("uflow_resume", 32'(o_bp_valid), 32'd1);
        drain(20);

        // Enable mask: only pair 1 served; dropping its enable mid-packet
        do_reset();
        en_s = 2'b10;
        push_pkt(1, 8'h80, 0);
        load(0, 8'h70, 4); load(1, 8'h80, 4);
        run_until_hs(8'h81, 20);
        en_s = 2'b00;
        drain(20);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mask_idle", 32'(o_busy), 32'd0);
        end
        check("mask_fifo0", 32'(fq0.size()), 32'd4);

        // Reset asserted while payload byte 2 is due
        en_s = 2'b11;
        sb.push_back('{data: 8'hA0, grant: 2'b01, tag: 1'b1, gap: 0});
        sb.push_back('{data: 8'h70, grant: 2'b01, tag: 1'b0, gap: 1});
        run_until_hs(8'h70, 20);
        rst_s = 0;
        tick();
        check("rstmid_valid", 32'(o_bp_valid), 32'd0);
        check("rstmid_pop", 32'(o_pktfifo_pop), 32'd0);
        tick();
        check("rstmid_grant", 32'(o_grant), 32'd0);
        check("rstmid_busy", 32'(o_busy), 32'd0);
        check("rstmid_valid2", 32'(o_bp_valid), 32'd0);
        check("rstmid_fifo0", 32'(fq0.size()), 32'd3);
        check("rstmid_sb", 32'(sb.size()), 32'd0);
        fq0.delete(); fq1.delete();
        rst_s = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
